// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   - PARITY_* : accepted values of the PARITY string parameter.
//   - rx_state_e : receive FSM states.
//   - parity_bad() : parity check of a received byte against its parity bit.
package uart_rx_pkg;

    localparam string PARITY_NONE = "NONE";
    localparam string PARITY_ODD  = "ODD";
    localparam string PARITY_EVEN = "EVEN";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // odd=1: data bits plus parity bit must hold an odd number of ones.
    // odd=0: they must hold an even number of ones.
    function automatic logic parity_bad(input logic [7:0] data,
                                        input logic       par,
                                        input logic       odd);
        logic sum;
        sum = ^data ^ par;
        return odd ? ~sum : sum;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-delivery interface of the UART receiver.
//   rx_data    : received byte, stable while rx_rdy=1
//   rx_rdy     : byte available, held until acknowledged
//   rx_ack     : consumer takes the byte on a clk edge with rx_rdy & rx_ack
//   parity_err : parity mismatch on the byte in rx_data
//   frame_err  : a stop bit was sampled 0 for the byte in rx_data
//   overrun    : sticky, a completed frame was dropped while rx_rdy=1
// master = receiver side, slave = consumer side.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_rdy,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_rdy,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
//   clk  : oversampling clock
//   rst  : synchronous reset, active low (all stages reset to 1 = idle line)
//   rx   : asynchronous serial input
//   rx_s : synchronized line (two flops behind rx)
//   fall : one-cycle pulse while rx_s has just gone 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    // prev is only an edge-detect delay; it does not add latency to rx_s.
    assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Delivers each byte through an rdy/ack handshake with
// parity, framing and overrun status.
//   clk : oversampling clock, OVERSAMPLE x baud
//   rst : synchronous reset, active low
//   rx  : asynchronous serial line, idle high
//   bus : byte-delivery interface (master side)
// Parameters: PARITY ("NONE"/"ODD"/"EVEN"), STOP_BIT (1 or 2),
//             OVERSAMPLE (even, >= 8).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter string       PARITY     = "ODD",
    parameter int unsigned STOP_BIT   = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    uart_rx_if.master   bus
);

    localparam int unsigned TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BIT - 1);
    localparam bit            PAR_EN    = (PARITY != PARITY_NONE);
    localparam bit            PAR_ODD   = (PARITY == PARITY_ODD);

    logic            rx_s;
    logic            fall;

    rx_state_e       state, state_n;
    logic [TW-1:0]   tick, tick_n, tick_inc;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, shreg_n;
    logic            perr_acc, perr_n;
    logic            ferr_acc, ferr_n;
    logic            done, done_n;
    logic            bit_end;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign tick_inc = (tick == LAST_TICK) ? '0 : tick + 1'b1;
    assign bit_end  = (tick == LAST_TICK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath update. START realigns the tick counter to
    // mid-bit, so every later sample (tick wrap) lands at the bit centre.
    // bit_cnt counts data bits, then is reused to count stop bits.
    always_comb begin
        state_n = state;
        tick_n  = tick_inc;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        perr_n  = perr_acc;
        ferr_n  = ferr_acc;
        done_n  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tick_n = '0;
                bit_n  = '0;
                if (fall) begin
                    state_n = ST_START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            ST_START: begin
                if (tick == MID_TICK) begin
                    tick_n  = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    perr_n  = parity_bad(shreg, rx_s, PAR_ODD);
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!rx_s) begin
                        ferr_n = 1'b1;
                    end
                    if (bit_cnt == LAST_STOP) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick     <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            perr_acc <= perr_n;
            ferr_acc <= ferr_n;
            done     <= done_n;
        end
    end

    // Output register. A completion with the old byte still unacknowledged
    // drops the new frame; an ack in the same cycle makes room for it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rx_data    <= '0;
            bus.rx_rdy     <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (done) begin
            if (!bus.rx_rdy || bus.rx_ack) begin
                bus.rx_data    <= shreg;
                bus.parity_err <= perr_acc;
                bus.frame_err  <= ferr_acc;
                bus.rx_rdy     <= 1'b1;
                bus.overrun    <= 1'b0;
            end else begin
                bus.overrun    <= 1'b1;
            end
        end else if (bus.rx_rdy && bus.rx_ack) begin
            bus.rx_rdy  <= 1'b0;
            bus.overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// u_dut : PARITY="ODD", STOP_BIT=1, OVERSAMPLE=16, driven on the clock grid.
// u_dut2: PARITY="NONE", STOP_BIT=2, driven with a bit period 1% long.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic clk;
    logic rst;
    logic rx;
    logic rx2;

    int n_cmp;
    int n_err;

    // Bit boundaries of the skewed line, in clocks (bit = 16.16 clocks).
    int k2;
    int cyc2;
    int target;

    uart_rx_if bus ();
    uart_rx_if bus2 ();

    uart_rx #(
        .PARITY     ("ODD"),
        .STOP_BIT   (1),
        .OVERSAMPLE (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    uart_rx #(
        .PARITY     ("NONE"),
        .STOP_BIT   (2),
        .OVERSAMPLE (16)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .rx  (rx2),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_head(d, par);
        drive_bit(stp);
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic drive2_bit(input logic b);
        rx2 = b;
        k2++;
        target = (k2 * 1616 + 50) / 100;
        repeat (target - cyc2) @(negedge clk);
        cyc2 = target;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        k2          = 0;
        cyc2        = 0;
        rst         = 1'b0;
        rx          = 1'b1;
        rx2         = 1'b1;
        bus.rx_ack  = 1'b0;
        bus2.rx_ack = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy",   8'(bus.rx_rdy), 8'h00);
        chk("rst_data",  bus.rx_data, 8'h00);
        chk("rst_perr",  8'(bus.parity_err), 8'h00);
        chk("rst_ferr",  8'(bus.frame_err), 8'h00);
        chk("rst_ovr",   8'(bus.overrun), 8'h00);
        chk("rst_state", 8'(u_dut.state), 8'(ST_IDLE));
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 0x01 with correct odd parity; rx_rdy 3 clk after mid-stop
        send_head(8'h01, 1'b0);
        rx = 1'b1;
        repeat (11) @(negedge clk);
        chk("t1_rdy_early", 8'(bus.rx_rdy), 8'h00);
        @(negedge clk);
        chk("t1_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t1_data", bus.rx_data, 8'h01);
        chk("t1_perr", 8'(bus.parity_err), 8'h00);
        chk("t1_ferr", 8'(bus.frame_err), 8'h00);
        // 2: ack in the rx_rdy cycle
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        chk("t2_ack_rdy", 8'(bus.rx_rdy), 8'h00);
        repeat (3) @(negedge clk);

        // 0xA5 has even weight, so par=0 violates odd parity
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("t2_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t2_data", bus.rx_data, 8'hA5);
        chk("t2_perr", 8'(bus.parity_err), 8'h01);
        chk("t2_ferr", 8'(bus.frame_err), 8'h00);
        do_ack();
        // Same byte with its correct parity bit
        send_frame(8'hA5, 1'b1, 1'b1);
        chk("t2b_data", bus.rx_data, 8'hA5);
        chk("t2b_perr", 8'(bus.parity_err), 8'h00);
        do_ack();

        // 3: stop bit 0 -> framing error, then a clean frame
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("t3_data", bus.rx_data, 8'h3C);
        chk("t3_ferr", 8'(bus.frame_err), 8'h01);
        chk("t3_perr", 8'(bus.parity_err), 8'h00);
        do_ack();
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h3D, 1'b0, 1'b1);
        chk("t3b_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t3b_data", bus.rx_data, 8'h3D);
        chk("t3b_ferr", 8'(bus.frame_err), 8'h00);
        chk("t3b_perr", 8'(bus.parity_err), 8'h00);
        do_ack();

        // 4: back to back without ack -> overrun, first byte kept
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("t4_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t4_data", bus.rx_data, 8'h11);
        chk("t4_ovr",  8'(bus.overrun), 8'h01);
        chk("t4_perr", 8'(bus.parity_err), 8'h00);
        do_ack();
        chk("t4_ack_rdy", 8'(bus.rx_rdy), 8'h00);
        chk("t4_ack_ovr", 8'(bus.overrun), 8'h00);

        // Ack landing in the completion cycle loads the new byte
        send_frame(8'h7E, 1'b1, 1'b1);
        send_head(8'h80, 1'b0);
        rx = 1'b1;
        repeat (11) @(negedge clk);
        chk("t4c_old_data", bus.rx_data, 8'h7E);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        chk("t4c_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t4c_data", bus.rx_data, 8'h80);
        chk("t4c_ovr",  8'(bus.overrun), 8'h00);
        repeat (4) @(negedge clk);
        do_ack();

        // 5: 6-clk glitch is rejected
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_glitch_rdy",   8'(bus.rx_rdy), 8'h00);
        chk("t5_glitch_state", 8'(u_dut.state), 8'(ST_IDLE));

        // Break: line held low
        for (int i = 0; i < 14; i++) drive_bit(1'b0);
        chk("t5_brk_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t5_brk_data", bus.rx_data, 8'h00);
        chk("t5_brk_ferr", 8'(bus.frame_err), 8'h01);
        chk("t5_brk_perr", 8'(bus.parity_err), 8'h01);
        do_ack();
        repeat (64) @(negedge clk);
        chk("t5_brk_hold_rdy",   8'(bus.rx_rdy), 8'h00);
        chk("t5_brk_hold_state", 8'(u_dut.state), 8'(ST_IDLE));
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Reset mid-DATA with a pending byte and overrun set
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        chk("t5_pre_ovr", 8'(bus.overrun), 8'h01);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_rdy",   8'(bus.rx_rdy), 8'h00);
        chk("t5_rst_data",  bus.rx_data, 8'h00);
        chk("t5_rst_ovr",   8'(bus.overrun), 8'h00);
        chk("t5_rst_ferr",  8'(bus.frame_err), 8'h00);
        chk("t5_rst_perr",  8'(bus.parity_err), 8'h00);
        chk("t5_rst_state", 8'(u_dut.state), 8'(ST_IDLE));
        rst = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("t5_5a_rdy",  8'(bus.rx_rdy), 8'h01);
        chk("t5_5a_data", bus.rx_data, 8'h5A);
        chk("t5_5a_perr", 8'(bus.parity_err), 8'h00);
        chk("t5_5a_ferr", 8'(bus.frame_err), 8'h00);
        do_ack();

        // 6: no parity, 2 stop bits, 1% slow line, 0xFF then 0x00
        drive2_bit(1'b0);
        for (int i = 0; i < 8; i++) drive2_bit(1'b1);
        drive2_bit(1'b1);
        drive2_bit(1'b1);
        // Start bit of the second frame, ack the first byte inside it
        rx2 = 1'b0;
        k2++;
        target = (k2 * 1616 + 50) / 100;
        chk("t6_ff_rdy",  8'(bus2.rx_rdy), 8'h01);
        chk("t6_ff_data", bus2.rx_data, 8'hFF);
        chk("t6_ff_perr", 8'(bus2.parity_err), 8'h00);
        chk("t6_ff_ferr", 8'(bus2.frame_err), 8'h00);
        bus2.rx_ack = 1'b1;
        @(negedge clk);
        bus2.rx_ack = 1'b0;
        @(negedge clk);
        repeat (target - cyc2 - 2) @(negedge clk);
        cyc2 = target;
        for (int i = 0; i < 8; i++) drive2_bit(1'b0);
        drive2_bit(1'b1);
        drive2_bit(1'b1);
        repeat (8) @(negedge clk);
        chk("t6_00_rdy",  8'(bus2.rx_rdy), 8'h01);
        chk("t6_00_data", bus2.rx_data, 8'h00);
        chk("t6_00_perr", 8'(bus2.parity_err), 8'h00);
        chk("t6_00_ferr", 8'(bus2.frame_err), 8'h00);
        chk("t6_00_ovr",  8'(bus2.overrun), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
